// File: rtl/mmio_console_port.sv
// MMIO console responder: register window with TX byte FIFO, status and cycle counter.
// Optional macro CONSOLE_IRQ_EN adds the irq output and the STATUS irq_en bit.
module mmio_console_port #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
   parameter int          FIFO_DEPTH = 8,
   parameter int          PTR_W      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
`ifdef CONSOLE_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [7:0]     OFF_TX  = 8'h00;
   localparam logic [7:0]     OFF_ST  = 8'h04;
   localparam logic [7:0]     OFF_CYC = 8'h08;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [31:0]      cyc_q, cyc_d;
   logic             phase_q, phase_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             wr_q, wr_d;
   logic [7:0]       off_q, off_d;

   logic [7:0] off;
   logic       acc_wr, fire, fire_tx, fire_st, fire_cyc;
   logic       full, empty, pop, push_ok;
   logic       irq_en;
   logic       unused_bits;

   assign off      = addr[7:0];
   assign hit      = (addr[31:8] == BASE_ADDR[31:8]);
   assign acc_wr   = hit && wr;
   // Held write strobes act once: only the first cycle of a same-offset run fires.
   assign fire     = acc_wr && !(wr_q && (off_q == off));
   assign fire_tx  = fire && (off == OFF_TX);
   assign fire_st  = fire && (off == OFF_ST);
   assign fire_cyc = fire && (off == OFF_CYC);

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign tx_valid = !empty;
   assign tx_data  = mem_q[rd_ptr_q];
   assign pop      = tx_valid && tx_ready;
   assign push_ok  = fire_tx && (!full || pop);
   assign rdata    = rdata_q;

   assign unused_bits = ^{wdata[31:8], BASE_ADDR[7:0]};

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata[7:0];
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (fire_tx && full && !pop) ovf_d = 1'b1;
      else if (fire_st && wdata[2]) ovf_d = 1'b0;
   end

   // Counter advances on every second edge; a load also restarts the phase.
   always_comb begin
      phase_d = !phase_q;
      cyc_d   = phase_q ? cyc_q + 32'd1 : cyc_q;
      if (fire_cyc) begin
         cyc_d   = '0;
         phase_d = 1'b0;
      end
   end

   always_comb begin
      wr_d    = acc_wr;
      off_d   = off;
      rdata_d = rdata_q;
      if (hit && !wr) begin
         case (off)
            OFF_ST:  rdata_d = {16'b0, 8'(count_q), 4'b0, irq_en, ovf_q, full, empty};
            OFF_CYC: rdata_d = cyc_q;
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         cyc_q    <= '0;
         phase_q  <= 1'b0;
         rdata_q  <= '0;
         wr_q     <= 1'b0;
         off_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         cyc_q    <= cyc_d;
         phase_q  <= phase_d;
         rdata_q  <= rdata_d;
         wr_q     <= wr_d;
         off_q    <= off_d;
      end
   end

`ifdef CONSOLE_IRQ_EN
   logic irq_en_q, irq_en_d, drained_q, drained_d, irq_q, irq_d;

   assign irq_en = irq_en_q;
   assign irq    = irq_q;

   // irq tracks next-cycle state so it lines up with the FIFO it describes.
   always_comb begin
      irq_en_d  = fire_st ? wdata[3] : irq_en_q;
      drained_d = drained_q;
      if (fire_tx) drained_d = 1'b0;
      else if (pop && !push_ok && (count_q == 1)) drained_d = 1'b1;
      irq_d = irq_en_d && (count_d == '0) && drained_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en_q  <= 1'b0;
         drained_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         irq_en_q  <= irq_en_d;
         drained_q <= drained_d;
         irq_q     <= irq_d;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_console_port.sv
// Randomized self-checking bench for mmio_console_port with a queue-based reference model.
module tb_mmio_console_port;

   localparam logic [31:0] BASE = 32'h0000_FF00;
   localparam logic [31:0] IDLE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic        wr, hit, tx_valid, tx_ready;
   logic [7:0]  tx_data;
`ifdef CONSOLE_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;

   logic [7:0] q[$];
   bit         ovf_m;
   bit         irq_en_m;

   mmio_console_port dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .wr       (wr),
      .wdata    (wdata),
      .rdata    (rdata),
      .hit      (hit),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
`ifdef CONSOLE_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [7:0] off, input logic [31:0] d, input int hold);
      addr = BASE | 32'(off);
      wr = 1'b1;
      wdata = d;
      repeat (hold) step();
      addr = IDLE;
      wr = 1'b0;
      step();
   endtask

   task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
      addr = BASE | 32'(off);
      wr = 1'b0;
      step();
      d = rdata;
      addr = IDLE;
   endtask

   function automatic logic [31:0] status_m();
      return {16'b0, 8'(q.size()), 4'b0, irq_en_m, ovf_m, q.size() == 8, q.size() == 0};
   endfunction

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b0; addr = IDLE; wr = 1'b0; wdata = '0; tx_ready = 1'b0;
      q.delete(); ovf_m = 0; irq_en_m = 0;
      repeat (2) step();
      checks++;
      if (rdata !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state rdata=%h tx_valid=%b tx_data=%h want 0/0/0", rdata, tx_valid, tx_data);
      end
      reset = 1'b1;
      step();
      checks++;
      if (hit !== 1'b0) begin failures++; $display("FAIL hit_idle got=%b want=0", hit); end
      addr = BASE | 32'h4;
      #1;
      checks++;
      if (hit !== 1'b1) begin failures++; $display("FAIL hit_base got=%b want=1", hit); end
      bus_read(8'h04, v);
      checks++;
      if (v !== status_m()) begin failures++; $display("FAIL reset_status got=%h want=%h", v, status_m()); end
   endtask

   task automatic test_hold_write();
      logic [31:0] v;
      bus_write(8'h00, 32'hDEAD_BE41, 3);
      q.push_back(8'h41);
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0100) begin failures++; $display("FAIL hold_status got=%h want=00000100", v); end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
         failures++; $display("FAIL hold_head valid=%b data=%h want 1/41", tx_valid, tx_data);
      end
      tx_ready = 1'b1; step(); tx_ready = 1'b0; void'(q.pop_front());
      checks++;
      if (tx_valid !== 1'b0) begin failures++; $display("FAIL hold_drain valid=%b want=0", tx_valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      for (int i = 1; i <= 9; i++) begin
         bus_write(8'h00, 32'(i), 1);
         if (q.size() < 8) q.push_back(8'(i)); else ovf_m = 1;
      end
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0806 || v !== status_m()) begin
         failures++; $display("FAIL ovf_status got=%h want=%h", v, status_m());
      end
      bus_write(8'h04, 32'h4, 1);
      ovf_m = 0;
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0802) begin failures++; $display("FAIL ovf_clear got=%h want=00000802", v); end
   endtask

   task automatic test_full_pushpop();
      logic [31:0] v;
      checks++;
      if (tx_data !== 8'h01) begin failures++; $display("FAIL full_head got=%h want=01", tx_data); end
      addr = BASE; wr = 1'b1; wdata = 32'h0A; tx_ready = 1'b1;
      step();
      void'(q.pop_front()); q.push_back(8'h0A);
      addr = IDLE; wr = 1'b0; tx_ready = 1'b0;
      step();
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0802 || v !== status_m()) begin
         failures++; $display("FAIL full_pushpop_status got=%h want=%h", v, status_m());
      end
      tx_ready = 1'b1;
      while (q.size() != 0) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
            failures++; $display("FAIL drain_order valid=%b data=%h want 1/%h", tx_valid, tx_data, q[0]);
         end
         step();
         void'(q.pop_front());
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty valid=%b want=0", tx_valid); end
   endtask

   task automatic test_cycle();
      logic [31:0] v1, v2, v3;
      bus_write(8'h08, 32'hFFFF_FFFF, 1);
      // one idle edge already taken by bus_write; counter halves edge count
      repeat (19) step();
      bus_read(8'h08, v1);
      checks++;
      if (v1 < 32'd9 || v1 > 32'd11) begin failures++; $display("FAIL cycle_count got=%0d want=10+-1", v1); end
      bus_write(8'h0C, 32'h0, 1);
      bus_read(8'h08, v2);
      checks++;
      if (v2 < v1 || v2 > v1 + 32'd4) begin failures++; $display("FAIL cycle_ff0c got=%0d want>=%0d", v2, v1); end
      bus_read(8'h0C, v3);
      checks++;
      if (v3 !== 32'h0) begin failures++; $display("FAIL read_unmapped got=%h want=0", v3); end
      bus_read(8'h08, v2);
      addr = 32'h0000_1000; wr = 1'b0;
      #1;
      checks++;
      if (hit !== 1'b0) begin failures++; $display("FAIL hit_miss got=%b want=0", hit); end
      step();
      checks++;
      if (rdata !== v2) begin failures++; $display("FAIL miss_hold got=%h want=%h", rdata, v2); end
      bus_read(8'h00, v3);
      checks++;
      if (v3 !== 32'h0) begin failures++; $display("FAIL read_txdata got=%h want=0", v3); end
   endtask

   task automatic test_irq();
      logic [31:0] v;
`ifdef CONSOLE_IRQ_EN
      bus_write(8'h04, 32'h8, 1);
      irq_en_m = 1;
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0009) begin failures++; $display("FAIL irq_en_status got=%h want=00000009", v); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b want=0", irq); end
      bus_write(8'h00, 32'h55, 1);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_drained got=%b want=1", irq); end
      bus_write(8'h00, 32'h66, 1);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_push got=%b want=0", irq); end
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      bus_write(8'h04, 32'h0, 1);
      irq_en_m = 0;
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_disable got=%b want=0", irq); end
`else
      bus_write(8'h04, 32'h8, 1);
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0001) begin failures++; $display("FAIL irq_en_absent got=%h want=00000001", v); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] v;
      bit prev_push = 0;
      for (int i = 0; i < 400; i++) begin
         bit push, rdy, pop;
         int sz;
         push = ($urandom_range(0, 2) == 0);
         rdy = $urandom_range(0, 1) == 1;
         addr = push ? BASE : IDLE;
         wr = push;
         wdata = $urandom;
         tx_ready = rdy;
         #1;
         checks++;
         if (tx_valid !== (q.size() != 0) || (q.size() != 0 && tx_data !== q[0])) begin
            failures++;
            $display("FAIL rand_head i=%0d valid=%b data=%h want %b/%h", i, tx_valid, tx_data,
                     q.size() != 0, (q.size() != 0) ? q[0] : 8'h00);
         end
         sz = q.size();
         pop = (sz != 0) && rdy;
         if (pop) void'(q.pop_front());
         if (push && !prev_push) begin
            if (sz < 8 || pop) q.push_back(wdata[7:0]); else ovf_m = 1;
         end
         prev_push = push;
         @(posedge clk); #1;
      end
      addr = IDLE; wr = 1'b0; tx_ready = 1'b0;
      step();
      bus_read(8'h04, v);
      checks++;
      if (v !== status_m()) begin failures++; $display("FAIL rand_status got=%h want=%h", v, status_m()); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      reset = 1'b0; step(); reset = 1'b1; step();
      q.delete(); ovf_m = 0; irq_en_m = 0;
      for (int i = 0; i < 5; i++) bus_write(8'h00, 32'($urandom), 1);
      tx_ready = 1'b1;
      step();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         failures++; $display("FAIL reset_mid valid=%b data=%h want 0/00", tx_valid, tx_data);
      end
      #1 reset = 1'b1; tx_ready = 1'b0;
      step();
      bus_read(8'h04, v);
      checks++;
      if (v !== 32'h0000_0001) begin failures++; $display("FAIL reset_mid_status got=%h want=00000001", v); end
   endtask

   initial begin
      test_reset();
      test_hold_write();
      test_overflow();
      test_full_pushpop();
      test_cycle();
      test_irq();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
